// File: rtl/mips_cache_pkg.sv
// Shared definitions for the MIPS direct-mapped instruction cache:
// refill FSM state encoding, word size and the address-field width helpers
// derived from the cache geometry.
package mips_cache_pkg;

  typedef enum logic [0:0] {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  // Bytes per instruction word and the byte-offset bits that go with it.
  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;

  // Bits that select a word inside a line.
  function automatic int offset_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits that select a line.
  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  // Whatever is left of a 32-bit address above offset and index.
  function automatic int tag_width(input int lines, input int words_per_line);
    return 32 - BYTE_OFF_W - offset_width(words_per_line) - index_width(lines);
  endfunction

endpackage

// File: rtl/mips_icache_refill_fsm.sv
// Refill sequencer for the instruction cache. Owns the LOOKUP/REFILL state,
// the beat counter, the latched line base and the memory request/address
// registers. A miss seen in LOOKUP latches the line base; each accepted beat
// advances the word address until the last beat returns to LOOKUP.
module mips_icache_refill_fsm
  import mips_cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_miss,
  input  logic [31:0] line_base,
  input  logic        mem_ready,
  output logic        in_lookup,
  output logic        fill_last,
  output logic        mem_request,
  output logic [31:0] mem_address
);

  localparam int OFF_W = offset_width(WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  icache_state_t    state_r, state_n_s;
  logic [OFF_W-1:0] beat_r, beat_n_s;
  logic [31:0]      base_r, base_n_s;
  logic [31:0]      addr_r, addr_n_s;
  logic             req_r, req_n_s;

  // State register plus the registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOOKUP;
      beat_r  <= {OFF_W{1'b0}};
      base_r  <= 32'h0000_0000;
      addr_r  <= 32'h0000_0000;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      beat_r  <= beat_n_s;
      base_r  <= base_n_s;
      addr_r  <= addr_n_s;
      req_r   <= req_n_s;
    end
  end

  // Next-state decode: start a refill on a miss, step beats on MemReady.
  always_comb begin
    state_n_s = state_r;
    beat_n_s  = beat_r;
    base_n_s  = base_r;
    req_n_s   = req_r;
    fill_last = 1'b0;
    case (state_r)
      LOOKUP: begin
        if (lookup_miss) begin
          state_n_s = REFILL;
          beat_n_s  = {OFF_W{1'b0}};
          base_n_s  = line_base;
          req_n_s   = 1'b1;
        end else begin
          req_n_s   = 1'b0;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          if (beat_r == LAST_BEAT) begin
            state_n_s = LOOKUP;
            beat_n_s  = {OFF_W{1'b0}};
            req_n_s   = 1'b0;
            fill_last = 1'b1;
          end else begin
            beat_n_s  = beat_r + {{(OFF_W-1){1'b0}}, 1'b1};
          end
        end else begin
          beat_n_s = beat_r;
        end
      end
      default: begin
        state_n_s = LOOKUP;
        beat_n_s  = {OFF_W{1'b0}};
        req_n_s   = 1'b0;
      end
    endcase
  end

  // Word address of the next beat; parked at zero while idle.
  always_comb begin
    if (req_n_s) begin
      addr_n_s = base_n_s | 32'({beat_n_s, 2'b00});
    end else begin
      addr_n_s = 32'h0000_0000;
    end
  end

  assign in_lookup   = (state_r == LOOKUP);
  assign mem_request = req_r;
  assign mem_address = addr_r;

endmodule

// File: rtl/mips_instruction_cache.sv
// Direct-mapped MIPS instruction cache. Holds valid/tag/data arrays in
// registers and performs a combinational tag compare against the current PC.
// Misses are refilled a full line at a time by mips_icache_refill_fsm.
// Optional feature macro: ICACHE_STATS_EN adds HitCount/MissCount outputs.
module mips_instruction_cache
  import mips_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        ClockPulse,
  input  logic        Reset,
  input  logic [31:0] InstructionAddress,
  output logic [31:0] Instruction,
  output logic        hit,
  output logic        MemRequest,
  output logic [31:0] MemAddress,
  input  logic [31:0] MemData,
  input  logic        MemReady
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int OFF_W  = offset_width(WORDS_PER_LINE);
  localparam int IDX_W  = index_width(LINES);
  localparam int TAG_W  = tag_width(LINES, WORDS_PER_LINE);
  localparam int IDX_LO = BYTE_OFF_W + OFF_W;
  localparam int TAG_LO = IDX_LO + IDX_W;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0] req_off_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic [31:0]      line_base_s;
  logic             tag_match_s;
  logic             in_lookup_s;
  logic             fill_last_s;
  logic             fill_we_s;
  logic [OFF_W-1:0] fill_off_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic             unused_bits_s;

  assign req_off_s   = InstructionAddress[IDX_LO-1:BYTE_OFF_W];
  assign req_idx_s   = InstructionAddress[TAG_LO-1:IDX_LO];
  assign req_tag_s   = InstructionAddress[31:TAG_LO];
  assign line_base_s = {InstructionAddress[31:IDX_LO], {IDX_LO{1'b0}}};

  // The beat address already carries the latched index, tag and word slot.
  assign fill_off_s  = MemAddress[IDX_LO-1:BYTE_OFF_W];
  assign fill_idx_s  = MemAddress[TAG_LO-1:IDX_LO];
  assign fill_tag_s  = MemAddress[31:TAG_LO];
  assign fill_we_s   = MemRequest & MemReady;

  assign unused_bits_s = ^{InstructionAddress[1:0], MemAddress[1:0]};

  mips_icache_refill_fsm #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_refill_fsm (
    .clk         (ClockPulse),
    .rst         (Reset),
    .lookup_miss (~tag_match_s),
    .line_base   (line_base_s),
    .mem_ready   (MemReady),
    .in_lookup   (in_lookup_s),
    .fill_last   (fill_last_s),
    .mem_request (MemRequest),
    .mem_address (MemAddress)
  );

  // Tag compare and word select; no forwarding while a refill is running.
  always_comb begin
    tag_match_s = 1'b0;
    hit         = 1'b0;
    Instruction = 32'h0000_0000;
    if (valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s)) begin
      tag_match_s = 1'b1;
    end else begin
      tag_match_s = 1'b0;
    end
    if (tag_match_s && in_lookup_s) begin
      hit         = 1'b1;
      Instruction = data_r[req_idx_s][req_off_s];
    end else begin
      hit         = 1'b0;
      Instruction = 32'h0000_0000;
    end
  end

  // Valid bits: cleared by reset, set when the last beat of a line lands.
  always_ff @(posedge ClockPulse or posedge Reset) begin
    if (Reset) begin
      valid_r <= {LINES{1'b0}};
    end else if (fill_last_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Data and tag storage; contents are meaningless until valid is set.
  always_ff @(posedge ClockPulse) begin
    if (fill_we_s) begin
      data_r[fill_idx_s][fill_off_s] <= MemData;
    end
    if (fill_last_s) begin
      tag_r[fill_idx_s] <= fill_tag_s;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Free-running hit/miss statistics, wrapping at 2^32.
  always_ff @(posedge ClockPulse or posedge Reset) begin
    if (Reset) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (hit) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (in_lookup_s && !tag_match_s) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign HitCount  = hit_count_r;
  assign MissCount = miss_count_r;
`endif

endmodule

// File: tb/tb_mips_instruction_cache.sv
// Self-checking bench for mips_instruction_cache (default geometry 16x4).
// A reference cache model predicts hit/miss, latency and refill addresses;
// expected words are queued at issue time and checked by a monitor process.
module tb_mips_instruction_cache;

  logic        ClockPulse;
  logic        Reset;
  logic [31:0] InstructionAddress;
  logic [31:0] Instruction;
  logic        hit;
  logic        MemRequest;
  logic [31:0] MemAddress;
  logic [31:0] MemData;
  logic        MemReady;
`ifdef ICACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  mips_instruction_cache dut (
    .ClockPulse         (ClockPulse),
    .Reset              (Reset),
    .InstructionAddress (InstructionAddress),
    .Instruction        (Instruction),
    .hit                (hit),
    .MemRequest         (MemRequest),
    .MemAddress         (MemAddress),
    .MemData            (MemData),
    .MemReady           (MemReady)
`ifdef ICACHE_STATS_EN
    ,
    .HitCount           (HitCount),
    .MissCount          (MissCount)
`endif
  );

  initial ClockPulse = 1'b0;
  always #5 ClockPulse = ~ClockPulse;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          hits_seen = 0;
  int          beats_given = 0;
  int          wait_cycles = 0;
  int          wait_cnt = 0;
  exp_t        exp_q[$];
  logic [31:0] refill_q[$];
  exp_t        mon_e;
  logic [31:0] mem [logic [31:0]];
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Main memory contents: fixed where preloaded, otherwise random on first touch.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Monitor: every hit cycle consumes one expected word.
  initial forever begin
    @(negedge ClockPulse);
    if (hit === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hit", {31'd0, hit}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr", Instruction, mon_e.data);
      end
      hits_seen++;
    end else begin
      check("instr_zero_when_no_hit", Instruction, 32'd0);
    end
  end

  // Memory responder: checks beat addresses, inserts waits, ignores idle cycles.
  initial forever begin
    @(negedge ClockPulse);
    if (MemRequest === 1'b1) begin
      check("no_hit_during_refill", {31'd0, hit}, 32'd0);
      if (refill_q.size() == 0) begin
        check("unexpected_request", {31'd0, MemRequest}, 32'd0);
        MemReady = 1'b0;
      end else begin
        check("mem_address", MemAddress, refill_q[0]);
        if (wait_cnt < wait_cycles) begin
          MemReady = 1'b0;
          MemData  = $urandom;
          wait_cnt++;
        end else begin
          MemReady = 1'b1;
          MemData  = mem_word(refill_q[0]);
          void'(refill_q.pop_front());
          wait_cnt = 0;
          beats_given++;
        end
      end
    end else begin
      wait_cnt = 0;
      MemReady = 1'($urandom_range(0, 1));
      MemData  = $urandom;
    end
  end

  task automatic model_invalidate();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // Called at posedge+1; asserts Reset, checks outputs drop at once, releases.
  task automatic do_reset();
    Reset = 1'b1;
    exp_q.delete();
    refill_q.delete();
    model_invalidate();
    #1;
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_memreq", {31'd0, MemRequest}, 32'd0);
    check("rst_memaddr", MemAddress, 32'd0);
    repeat (2) @(posedge ClockPulse);
    #1;
    Reset = 1'b0;
  endtask

  // One fetch: predict, queue expectations, present address, wait for hit.
  task automatic access(input logic [31:0] a, input int w, input bit chk_lat);
    int          idx;
    logic [23:0] tg;
    int          lat_exp;
    int          cyc;
    int          prev;
    logic [31:0] base;
    idx  = int'((a >> 4) & 32'hF);
    tg   = a[31:8];
    base = a & 32'hFFFF_FFF0;
    wait_cycles = w;
    exp_q.push_back('{addr: a, data: mem_word(a & 32'hFFFF_FFFC)});
    if (m_valid[idx] && m_tag[idx] == tg) begin
      lat_exp = 0;
    end else begin
      for (int k = 0; k < 4; k++) refill_q.push_back(base + 32'(4 * k));
      lat_exp = 1 + 4 * (w + 1);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    InstructionAddress = a;
    prev = hits_seen;
    cyc  = 0;
    while (hits_seen == prev && cyc < 400) begin
      @(posedge ClockPulse);
      cyc++;
    end
    if (hits_seen == prev) begin
      check("hit_timeout", 32'd0, 32'd1);
    end else if (chk_lat) begin
      check("latency", 32'(cyc - 1), 32'(lat_exp));
    end
    #1;
  endtask

  initial begin
    int guard;
    Reset = 1'b1;
    InstructionAddress = 32'h0;
    MemReady = 1'b0;
    MemData = 32'h0;
    model_invalidate();
    for (int k = 0; k < 4; k++) mem[32'h40 + 32'(4 * k)] = 32'hA0 + 32'(k);
    @(posedge ClockPulse);
    #1;

    // Cold miss with zero-wait memory, then a zero-cycle hit on the same line.
    do_reset();
    access(32'h0000_0040, 0, 1'b1);
    access(32'h0000_004C, 0, 1'b1);

    // Same miss with three wait cycles before every beat.
    do_reset();
    access(32'h0000_0040, 3, 1'b1);
    access(32'h0000_0044, 0, 1'b1);
    access(32'h0000_0048, 0, 1'b1);
    access(32'h0000_004C, 0, 1'b1);

    // Conflict eviction on index 4.
    access(32'h0000_0140, 0, 1'b1);
    access(32'h0000_0040, 0, 1'b1);

    // Address moves away during a refill; the latched line still completes.
    do_reset();
    wait_cycles = 0;
    beats_given = 0;
    for (int k = 0; k < 4; k++) refill_q.push_back(32'h40 + 32'(4 * k));
    m_valid[4] = 1'b1;
    m_tag[4]   = 24'h0;
    InstructionAddress = 32'h0000_0040;
    guard = 0;
    while (beats_given < 1 && guard < 50) begin
      @(posedge ClockPulse);
      guard++;
    end
    check("beat1_seen", 32'(beats_given >= 1), 32'd1);
    #1;
    access(32'h0000_0080, 0, 1'b0);
    access(32'h0000_0040, 0, 1'b1);

    // Reset mid-refill after two beats, then refill again from beat 0.
    do_reset();
    wait_cycles = 0;
    beats_given = 0;
    for (int k = 0; k < 4; k++) refill_q.push_back(32'h40 + 32'(4 * k));
    InstructionAddress = 32'h0000_0040;
    guard = 0;
    while (beats_given < 2 && guard < 50) begin
      @(posedge ClockPulse);
      guard++;
    end
    check("beat2_seen", 32'(beats_given >= 2), 32'd1);
    #1;
    do_reset();
    access(32'h0000_0040, 0, 1'b1);

    // Randomized fetch stream over a few indices and tags.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      access(a, $urandom_range(0, 3), 1'b1);
    end

`ifdef ICACHE_STATS_EN
    // One miss followed by seven hit cycles.
    do_reset();
    access(32'h0000_0200, 0, 1'b1);
    for (int n = 0; n < 6; n++) access(32'h0000_0200, 0, 1'b1);
    check("miss_count", MissCount, 32'd1);
    check("hit_count", HitCount, 32'd7);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("refills_drained", 32'(refill_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
